// File: rtl/puzzle_pkg.sv
// Shared types, constants and small helpers for the 3x3 sliding-tile play engine.
// A grid is 9 nibbles packed with cell i at bits [4*i+3:4*i].
package puzzle_pkg;

    typedef enum logic [2:0] {
        ST_EMPTY  = 3'd0,
        ST_SCAN   = 3'd1,
        ST_PLAY   = 3'd2,
        ST_SOLVED = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    localparam int          GRID_W       = 36;
    localparam logic [3:0]  CELL_FIRST   = 4'd0;
    localparam logic [3:0]  CELL_LAST    = 4'd8;
    localparam logic [3:0]  ROW_STRIDE   = 4'd3;
    localparam logic [3:0]  CELL_MAX_VAL = 4'd8;

    // Goal 1 2 3 / 4 5 6 / 7 8 0, cell 8 in the top nibble.
    localparam logic [GRID_W-1:0] GOAL = {4'd0, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};

    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    function automatic logic [6:0] seg_digit(input logic [3:0] v);
        case (v)
            4'd0:    seg_digit = 7'b1000000;
            4'd1:    seg_digit = 7'b1111001;
            4'd2:    seg_digit = 7'b0100100;
            4'd3:    seg_digit = 7'b0110000;
            4'd4:    seg_digit = 7'b0011001;
            4'd5:    seg_digit = 7'b0010010;
            4'd6:    seg_digit = 7'b0000010;
            4'd7:    seg_digit = 7'b1111000;
            4'd8:    seg_digit = 7'b0000000;
            4'd9:    seg_digit = 7'b0010000;
            default: seg_digit = SEG_OFF;
        endcase
    endfunction

    function automatic logic [3:0] cell_at(input logic [GRID_W-1:0] g, input logic [3:0] i);
        case (i)
            4'd0:    cell_at = g[3:0];
            4'd1:    cell_at = g[7:4];
            4'd2:    cell_at = g[11:8];
            4'd3:    cell_at = g[15:12];
            4'd4:    cell_at = g[19:16];
            4'd5:    cell_at = g[23:20];
            4'd6:    cell_at = g[27:24];
            4'd7:    cell_at = g[31:28];
            4'd8:    cell_at = g[35:32];
            default: cell_at = 4'd0;
        endcase
    endfunction

    function automatic logic [1:0] cell_col(input logic [3:0] i);
        case (i)
            4'd0, 4'd3, 4'd6: cell_col = 2'd0;
            4'd1, 4'd4, 4'd7: cell_col = 2'd1;
            4'd2, 4'd5, 4'd8: cell_col = 2'd2;
            default:          cell_col = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/puzzle_play_engine_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter, one-cycle pulse on
// each accepted rising level.
module btn_debounce #(
    parameter int DB_W = 16
) (
    input  logic clk,
    input  logic clr,
    input  logic btn_i,
    output logic pulse_o
);

    localparam logic [DB_W-1:0] CNT_ONE = {{(DB_W-1){1'b0}}, 1'b1};
    localparam logic [DB_W-1:0] CNT_MAX = {DB_W{1'b1}};

    logic [1:0]      sync_q;
    logic            level_q;
    logic [DB_W-1:0] cnt_q;
    logic            pulse_q;

    // The level flips only after the synchronised input differed for 2^DB_W edges.
    always_ff @(posedge clk) begin
        if (clr) begin
            sync_q  <= 2'b00;
            level_q <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            pulse_q <= 1'b0;
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                cnt_q   <= '0;
                level_q <= sync_q[1];
                pulse_q <= sync_q[1];
            end else begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/puzzle_play_engine.sv
// Sliding-tile play engine: captures and validates a 3x3 grid, applies debounced
// direction moves to the blank, detects the goal and drives a 4-digit display.
module puzzle_play_engine
    import puzzle_pkg::*;
#(
    parameter int CLKDIV_W = 20,
    parameter int DB_W     = 16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        load,
    input  logic [11:0] row1_in,
    input  logic [11:0] row2_in,
    input  logic [11:0] row3_in,
    input  logic        btnu,
    input  logic        btnd,
    input  logic        btnl,
    input  logic        btnr,
    input  logic [2:0]  sel,
    output logic [6:0]  a_to_g,
    output logic [3:0]  an,
    output logic        dp,
    output logic        solved,
    output logic        err,
    output logic [7:0]  move_count
);

    localparam logic [CLKDIV_W-1:0] DIV_ONE = {{(CLKDIV_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [GRID_W-1:0]   grid_q, grid_d;
    logic [3:0]          blank_q, blank_d;
    logic [3:0]          idx_q, idx_d;
    logic [3:0]          zeros_q, zeros_d;
    logic                bad_q, bad_d;
    logic                solved_q, solved_d;
    logic                err_q, err_d;
    logic [7:0]          count_q, count_d;
    logic [CLKDIV_W-1:0] clkdiv_q;
    logic [6:0]          seg_q, seg_d;
    logic [3:0]          an_q, an_d;

    logic       pu_s, pd_s, pl_s, pr_s;
    logic [3:0] tgt_s, tile_s, scan_cell_s, zeros_s;
    logic       legal_s, bad_s;
    logic [1:0] digit_s;
    logic [3:0] row_base_s, disp_val_s;
    logic       row_ok_s;

    btn_debounce #(.DB_W(DB_W)) u_db_u (.clk(clk), .clr(clr), .btn_i(btnu), .pulse_o(pu_s));
    btn_debounce #(.DB_W(DB_W)) u_db_d (.clk(clk), .clr(clr), .btn_i(btnd), .pulse_o(pd_s));
    btn_debounce #(.DB_W(DB_W)) u_db_l (.clk(clk), .clr(clr), .btn_i(btnl), .pulse_o(pl_s));
    btn_debounce #(.DB_W(DB_W)) u_db_r (.clk(clk), .clr(clr), .btn_i(btnr), .pulse_o(pr_s));

    // Pick the highest-priority direction (U>D>L>R); its legality alone decides the move.
    always_comb begin
        tgt_s   = blank_q;
        legal_s = 1'b0;
        if (pu_s) begin
            tgt_s   = blank_q - ROW_STRIDE;
            legal_s = (blank_q >= ROW_STRIDE);
        end else if (pd_s) begin
            tgt_s   = blank_q + ROW_STRIDE;
            legal_s = (blank_q <= (CELL_LAST - ROW_STRIDE));
        end else if (pl_s) begin
            tgt_s   = blank_q - 4'd1;
            legal_s = (cell_col(blank_q) != 2'd0);
        end else if (pr_s) begin
            tgt_s   = blank_q + 4'd1;
            legal_s = (cell_col(blank_q) != 2'd2);
        end else begin
            tgt_s   = blank_q;
            legal_s = 1'b0;
        end
        tile_s = cell_at(grid_q, tgt_s);
    end

    // Engine next state: load beats everything, SCAN walks one cell per cycle.
    always_comb begin
        state_d     = state_q;
        grid_d      = grid_q;
        blank_d     = blank_q;
        idx_d       = idx_q;
        zeros_d     = zeros_q;
        bad_d       = bad_q;
        solved_d    = solved_q;
        err_d       = err_q;
        count_d     = count_q;
        scan_cell_s = cell_at(grid_q, idx_q);
        zeros_s     = zeros_q + ((scan_cell_s == 4'd0) ? 4'd1 : 4'd0);
        bad_s       = bad_q | (scan_cell_s > CELL_MAX_VAL);
        if (load) begin
            state_d  = ST_SCAN;
            grid_d   = {row3_in[3:0], row3_in[7:4], row3_in[11:8],
                        row2_in[3:0], row2_in[7:4], row2_in[11:8],
                        row1_in[3:0], row1_in[7:4], row1_in[11:8]};
            blank_d  = CELL_FIRST;
            idx_d    = CELL_FIRST;
            zeros_d  = 4'd0;
            bad_d    = 1'b0;
            solved_d = 1'b0;
            err_d    = 1'b0;
            count_d  = 8'd0;
        end else begin
            case (state_q)
                ST_SCAN: begin
                    zeros_d = zeros_s;
                    bad_d   = bad_s;
                    idx_d   = idx_q + 4'd1;
                    if (scan_cell_s == 4'd0) begin
                        blank_d = idx_q;
                    end else begin
                        blank_d = blank_q;
                    end
                    if (idx_q == CELL_LAST) begin
                        if ((zeros_s == 4'd1) && !bad_s) begin
                            if (grid_q == GOAL) begin
                                state_d  = ST_SOLVED;
                                solved_d = 1'b1;
                            end else begin
                                state_d = ST_PLAY;
                            end
                        end else begin
                            state_d = ST_ERROR;
                            err_d   = 1'b1;
                        end
                    end else begin
                        state_d = ST_SCAN;
                    end
                end
                ST_PLAY: begin
                    if (grid_q == GOAL) begin
                        state_d  = ST_SOLVED;
                        solved_d = 1'b1;
                    end else if (legal_s) begin
                        for (int i = 0; i < 9; i++) begin
                            if (4'(i) == blank_q) begin
                                grid_d[4*i +: 4] = tile_s;
                            end else if (4'(i) == tgt_s) begin
                                grid_d[4*i +: 4] = 4'd0;
                            end else begin
                                grid_d[4*i +: 4] = grid_q[4*i +: 4];
                            end
                        end
                        blank_d = tgt_s;
                        count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                    end else begin
                        state_d = ST_PLAY;
                    end
                end
                ST_EMPTY, ST_SOLVED, ST_ERROR: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Display: lowest set sel bit picks the row; digit 3 flags a solved grid.
    always_comb begin
        digit_s    = clkdiv_q[CLKDIV_W-1 -: 2];
        row_ok_s   = 1'b1;
        row_base_s = 4'd0;
        if (sel[0]) begin
            row_base_s = 4'd0;
        end else if (sel[1]) begin
            row_base_s = 4'd3;
        end else if (sel[2]) begin
            row_base_s = 4'd6;
        end else begin
            row_ok_s = 1'b0;
        end
        disp_val_s = cell_at(grid_q, row_base_s + (4'd2 - {2'b00, digit_s}));
        an_d  = 4'b1111;
        seg_d = SEG_OFF;
        if (!row_ok_s) begin
            an_d  = 4'b1111;
            seg_d = SEG_OFF;
        end else begin
            an_d = ~(4'b0001 << digit_s);
            if ((state_q == ST_EMPTY) || (state_q == ST_ERROR)) begin
                seg_d = SEG_DASH;
            end else if (digit_s == 2'd3) begin
                seg_d = solved_q ? SEG_DASH : SEG_OFF;
            end else if (disp_val_s == 4'd0) begin
                seg_d = SEG_OFF;
            end else begin
                seg_d = seg_digit(disp_val_s);
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= ST_EMPTY;
            grid_q   <= '0;
            blank_q  <= 4'd0;
            idx_q    <= 4'd0;
            zeros_q  <= 4'd0;
            bad_q    <= 1'b0;
            solved_q <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= 8'd0;
            clkdiv_q <= '0;
            seg_q    <= SEG_OFF;
            an_q     <= 4'b1111;
        end else begin
            state_q  <= state_d;
            grid_q   <= grid_d;
            blank_q  <= blank_d;
            idx_q    <= idx_d;
            zeros_q  <= zeros_d;
            bad_q    <= bad_d;
            solved_q <= solved_d;
            err_q    <= err_d;
            count_q  <= count_d;
            clkdiv_q <= clkdiv_q + DIV_ONE;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end
    end

    assign a_to_g     = seg_q;
    assign an         = an_q;
    assign dp         = 1'b1;
    assign solved     = solved_q;
    assign err        = err_q;
    assign move_count = count_q;

endmodule

// File: tb/tb_puzzle_play_engine.sv
// Directed plus randomized bench for puzzle_play_engine against a cell-array model.
module tb_puzzle_play_engine;
    import puzzle_pkg::*;

    localparam int DBW      = 2;
    localparam int HOLD_MIN = 1 << DBW;

    logic        clk = 1'b0;
    logic        clr, load;
    logic [11:0] r1, r2, r3;
    logic        bu, bd, bl, br;
    logic [2:0]  sel;
    logic [6:0]  a_to_g;
    logic [3:0]  an;
    logic        dp, solved, err;
    logic [7:0]  move_count;

    int vectors = 0;
    int miscompares = 0;

    int mcell[9];
    int mcount;
    bit mvalid, msolved, mempty;
    logic [6:0] seg_tab[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    puzzle_play_engine #(.CLKDIV_W(4), .DB_W(DBW)) dut (
        .clk(clk), .clr(clr), .load(load),
        .row1_in(r1), .row2_in(r2), .row3_in(r3),
        .btnu(bu), .btnd(bd), .btnl(bl), .btnr(br),
        .sel(sel), .a_to_g(a_to_g), .an(an), .dp(dp),
        .solved(solved), .err(err), .move_count(move_count)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_goal();
        for (int i = 0; i < 9; i++)
            if (mcell[i] != ((i == 8) ? 0 : i + 1)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [35:0] model_grid();
        logic [35:0] g;
        for (int i = 0; i < 9; i++) g[4*i +: 4] = 4'(mcell[i]);
        return g;
    endfunction

    function automatic state_t model_state();
        if (mempty) return ST_EMPTY;
        if (!mvalid) return ST_ERROR;
        if (msolved) return ST_SOLVED;
        return ST_PLAY;
    endfunction

    function automatic logic [6:0] exp_seg(input int k, input logic [2:0] s);
        int row, v;
        if (mempty || !mvalid) return 7'b0111111;
        if (k == 3) return msolved ? 7'b0111111 : 7'b1111111;
        row = s[0] ? 0 : (s[1] ? 1 : 2);
        v = mcell[row*3 + (2 - k)];
        if (v == 0 || v > 9) return 7'b1111111;
        return seg_tab[v];
    endfunction

    task automatic model_load(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
        int zeros;
        bit bad;
        logic [11:0] rows[3];
        rows = '{a, b, c};
        zeros = 0;
        bad = 1'b0;
        for (int i = 0; i < 9; i++) begin
            mcell[i] = int'(rows[i/3][11 - 4*(i%3) -: 4]);
            if (mcell[i] == 0) zeros++;
            if (mcell[i] > 8) bad = 1'b1;
        end
        mvalid  = (zeros == 1) && !bad;
        msolved = mvalid && model_goal();
        mcount  = 0;
        mempty  = 1'b0;
    endtask

    task automatic model_move(input bit u, input bit d, input bit l, input bit r);
        int b, t, tmp;
        bit legal;
        if (mempty || !mvalid || msolved) return;
        b = 0;
        for (int i = 0; i < 9; i++) if (mcell[i] == 0) b = i;
        if (u)      begin legal = (b / 3) > 0; t = b - 3; end
        else if (d) begin legal = (b / 3) < 2; t = b + 3; end
        else if (l) begin legal = (b % 3) > 0; t = b - 1; end
        else if (r) begin legal = (b % 3) < 2; t = b + 1; end
        else return;
        if (!legal) return;
        tmp = mcell[t]; mcell[t] = 0; mcell[b] = tmp;
        if (mcount < 255) mcount++;
        if (model_goal()) msolved = 1'b1;
    endtask

    task automatic check_all(input string tag);
        check({tag, "/grid"},  64'(dut.grid_q), 64'(model_grid()));
        check({tag, "/count"}, 64'(move_count), 64'(mcount));
        check({tag, "/solved"}, 64'(solved), 64'(msolved));
        check({tag, "/err"},   64'(err), 64'(!mempty && !mvalid));
        check({tag, "/state"}, 64'(dut.state_q), 64'(model_state()));
    endtask

    task automatic do_load(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c);
        load = 1'b1; r1 = a; r2 = b; r3 = c;
        model_load(a, b, c);
        tick(1);
        load = 1'b0;
        tick(8);
        check("scan_n9", 64'(dut.state_q), 64'(ST_SCAN));
        tick(1);
        check_all("load_n10");
    endtask

    task automatic press(input bit u, input bit d, input bit l, input bit r, input int hold);
        bu = u; bd = d; bl = l; br = r;
        tick(hold);
        bu = 1'b0; bd = 1'b0; bl = 1'b0; br = 1'b0;
        if (hold >= HOLD_MIN) model_move(u, d, l, r);
        tick(12);
        check_all("press");
    endtask

    task automatic check_display(input logic [2:0] s);
        int k;
        sel = s;
        tick(3);
        for (int c = 0; c < 16; c++) begin
            tick(1);
            check("dp", 64'(dp), 64'(1));
            if (s == 3'b000) begin
                check("an_off", 64'(an), 64'(4'hF));
            end else begin
                k = -1;
                for (int j = 0; j < 4; j++) if (an == ~(4'b0001 << j)) k = j;
                check("an_onehot", 64'(k >= 0), 64'(1));
                if (k >= 0) check("segs", 64'(a_to_g), 64'(exp_seg(k, s)));
            end
        end
    endtask

    initial begin
        logic [11:0] ra, rb, rc;
        int perm[9];
        int tmp, j, hold, mask;

        clr = 1'b1; load = 1'b0; r1 = 12'h0; r2 = 12'h0; r3 = 12'h0;
        bu = 1'b0; bd = 1'b0; bl = 1'b0; br = 1'b0; sel = 3'b001;
        for (int i = 0; i < 9; i++) mcell[i] = 0;
        mcount = 0; mvalid = 1'b0; msolved = 1'b0; mempty = 1'b1;
        tick(3);
        check("rst_seg", 64'(a_to_g), 64'(7'h7F));
        check("rst_an", 64'(an), 64'(4'hF));
        check_all("reset");
        clr = 1'b0;
        check_display(3'b001);

        // One move from solved: right completes the goal; solved lags the count by a cycle.
        do_load(12'h123, 12'h456, 12'h708);
        br = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick(1);
            if (move_count != 8'd0) break;
        end
        check("mv_seen", 64'(move_count), 64'(1));
        check("solved_lag", 64'(solved), 64'(0));
        tick(1);
        check("solved_next", 64'(solved), 64'(1));
        br = 1'b0;
        model_move(1'b0, 1'b0, 1'b0, 1'b1);
        tick(12);
        check_all("solved");
        press(1'b0, 1'b0, 1'b1, 1'b0, 6);
        check_display(3'b110);
        check_display(3'b000);

        // Corner blank: up and left illegal, down legal.
        do_load(12'h012, 12'h345, 12'h678);
        press(1'b1, 1'b0, 1'b0, 1'b0, 6);
        press(1'b0, 1'b0, 1'b1, 1'b0, 6);
        press(1'b0, 1'b1, 1'b0, 1'b0, 6);
        check_display(3'b100);

        // Two blanks: error, dashes, moves ignored.
        do_load(12'h103, 12'h456, 12'h708);
        check_display(3'b001);
        press(1'b1, 1'b0, 1'b0, 1'b0, 6);
        press(1'b0, 1'b1, 1'b0, 1'b0, 6);

        // Simultaneous down+right from centre: down wins.
        do_load(12'h123, 12'h405, 12'h678);
        press(1'b0, 1'b1, 1'b0, 1'b1, 6);

        // Glitch shorter than the debounce window, then a long hold.
        press(1'b1, 1'b0, 1'b0, 1'b0, 2);
        press(1'b1, 1'b0, 1'b0, 1'b0, 20);

        // Move pulse reaches the engine in the same cycle as load.
        bl = 1'b1;
        tick(6);
        load = 1'b1; r1 = 12'h413; r2 = 12'h526; r3 = 12'h780;
        model_load(12'h413, 12'h526, 12'h780);
        tick(1);
        load = 1'b0;
        tick(9);
        check_all("load_vs_move");
        bl = 1'b0;
        tick(12);
        check_all("load_vs_move_rel");

        // clr in the middle of SCAN.
        load = 1'b1; r1 = 12'h123; r2 = 12'h456; r3 = 12'h780;
        tick(1);
        load = 1'b0;
        tick(3);
        clr = 1'b1;
        tick(1);
        for (int i = 0; i < 9; i++) mcell[i] = 0;
        mcount = 0; mvalid = 1'b0; msolved = 1'b0; mempty = 1'b1;
        check("clr_seg", 64'(a_to_g), 64'(7'h7F));
        check("clr_an", 64'(an), 64'(4'hF));
        check_all("clr_scan");
        clr = 1'b0;
        tick(2);

        // Randomized loads and presses.
        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(3, 0) != 0) begin
                for (int i = 0; i < 9; i++) perm[i] = i;
                for (int i = 8; i > 0; i--) begin
                    j = $urandom_range(i, 0);
                    tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
                end
                ra = {4'(perm[0]), 4'(perm[1]), 4'(perm[2])};
                rb = {4'(perm[3]), 4'(perm[4]), 4'(perm[5])};
                rc = {4'(perm[6]), 4'(perm[7]), 4'(perm[8])};
            end else begin
                ra = 12'($urandom); rb = 12'($urandom); rc = 12'($urandom);
            end
            do_load(ra, rb, rc);
            for (int p = 0; p < 6; p++) begin
                mask = $urandom_range(15, 0);
                hold = ($urandom_range(3, 0) == 0) ? 2 : $urandom_range(10, 6);
                press(mask[3], mask[2], mask[1], mask[0], hold);
            end
            if (it % 5 == 0) check_display(3'($urandom_range(7, 0)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
